// File: rtl/dds_radar_wave.sv
// -----------------------------------------------------------------------------
// dds_radar_wave
//   Direct digital synthesizer for radar test waveforms. One 22-bit sample per
//   clock, {I[10:0], Q[10:0]} two's complement, straight to the DAC.
//
// Ports
//   sys_clk    in   1   200 MHz clock
//   sys_rst_n  in   1   asynchronous active-low reset
//   wave_sel   in   6   one-hot waveform: CW, up-chirp, down-chirp, triangle FM,
//                       Barker-13 BPSK, square
//   F          in   9   carrier / sweep frequency, 100 kHz units
//   T          in  11   pulse repetition period, 1 us units (0 = no pulsing)
//   mode_sel   in   4   0010 pulsed, 0100 pulsed + alternate-pulse inversion,
//                       anything else continuous
//   Z          in   7   pulse width, 100 ns units
//   dac_data   out 22   {I, Q}
//
// Timing: dac_data after edge n+2 reflects the phase register after edge n
// (phase reg -> LUT reg -> output reg). Gate, waveform and mode decisions are
// taken in the same cycle as the LUT read so they line up with that phase.
// -----------------------------------------------------------------------------
module dds_radar_wave #(
    parameter int unsigned FTW_UNIT  = 2147484,
    parameter int unsigned PRT_CLKS  = 200,
    parameter int unsigned PW_CLKS   = 20,
    parameter int unsigned CHIP_CLKS = 20,
    parameter int unsigned AMP       = 1023,
    parameter int unsigned RAMP_BITS = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [5:0]  wave_sel,
    input  logic [8:0]  F,
    input  logic [10:0] T,
    input  logic [3:0]  mode_sel,
    input  logic [6:0]  Z,
    output logic [21:0] dac_data
);

    localparam int          CW     = 20;               // period counter width
    localparam int          PW     = 32 + RAMP_BITS;   // FTW x ramp product width
    localparam int          QN     = 257;              // quarter-wave points incl. 90 deg
    localparam logic [12:0] BARKER = 13'b1111100110101;
    localparam logic [7:0]  CHIP_LAST = 8'(CHIP_CLKS - 1);
    localparam logic [10:0] AMP_P  = 11'(AMP);
    localparam logic [10:0] AMP_N  = 11'(2048 - AMP);

    // Quarter-wave table round(AMP*sin(pi*k/512)), k = 0..256, built at
    // elaboration with a fixed-point Taylor series (angle in Q28).
    function automatic logic [QN*10-1:0] build_qtab();
        logic [QN*10-1:0] tab;
        longint x, x2, term, acc, v;
        tab = '0;
        for (int k = 0; k < QN; k++) begin
            x    = (longint'(k) * 64'sd13493037705) / 64'sd8192;  // pi*2^32 scaled
            x2   = (x * x) / (64'sd1 <<< 28);
            term = x;
            acc  = x;
            for (int n = 1; n <= 10; n++) begin
                term = -((term * x2) / (64'sd1 <<< 28)) / longint'((2 * n) * (2 * n + 1));
                acc  = acc + term;
            end
            v = (acc * longint'(AMP) + (64'sd1 <<< 27)) / (64'sd1 <<< 28);
            tab[k*10 +: 10] = 10'(v);
        end
        return tab;
    endfunction

    localparam logic [QN*10-1:0] QTAB = build_qtab();

    // Full 1024-point sine from the quarter table by symmetry.
    function automatic logic [10:0] lut(input logic [9:0] idx);
        logic [8:0]  a;
        logic [10:0] mag;
        a   = idx[8] ? (9'd256 - {1'b0, idx[7:0]}) : {1'b0, idx[7:0]};
        mag = {1'b0, QTAB[a*10 +: 10]};
        return idx[9] ? (11'd0 - mag) : mag;
    endfunction

    // State
    logic [31:0]          r_phase;
    logic [RAMP_BITS:0]   r_ramp;      // one extra bit for the triangle half
    logic [7:0]           r_chip_cnt;
    logic [3:0]           r_chip_idx;
    logic [CW-1:0]        r_per;
    logic                 r_odd;       // current pulse number is odd
    logic [5:0]           r_wsel;
    // Pipeline
    logic [10:0]          r_sin, r_cos;
    logic                 r_en1, r_sq1;
    logic [21:0]          r_dac;

    logic [31:0]          w_ftw, w_ftw_inst, w_lphase;
    logic [RAMP_BITS-1:0] w_rfac;
    logic                 w_use_ramp;
    logic [PW-1:0]        w_prod;
    logic [CW-1:0]        w_lim, w_pw, w_per_nxt;
    logic                 w_valid, w_pulsed, w_wrap, w_clear, w_gate, w_en, w_code_bit;

    always_comb begin
        w_ftw      = 32'(F * FTW_UNIT);
        w_use_ramp = 1'b1;
        w_rfac     = r_ramp[RAMP_BITS-1:0];
        case (wave_sel)
            6'b000010: w_rfac = r_ramp[RAMP_BITS-1:0];
            6'b000100: w_rfac = ~r_ramp[RAMP_BITS-1:0];   // 4095 - ramp
            6'b001000: w_rfac = r_ramp[RAMP_BITS] ? ~r_ramp[RAMP_BITS-1:0]
                                                  :  r_ramp[RAMP_BITS-1:0];
            default:   w_use_ramp = 1'b0;
        endcase
        w_prod     = {{RAMP_BITS{1'b0}}, w_ftw} * {32'd0, w_rfac};
        w_ftw_inst = w_use_ramp ? 32'(w_prod >> RAMP_BITS) : w_ftw;

        w_lim = CW'(T * PRT_CLKS);
        w_pw  = CW'(Z * PW_CLKS);
        // Also catches a counter left above a freshly shortened period.
        if (T == '0 || r_per >= w_lim - 1'b1) w_per_nxt = '0;
        else                                  w_per_nxt = r_per + 1'b1;
        w_wrap   = (T != '0) && (w_per_nxt == '0);   // next cycle is pulse_start
        w_pulsed = (mode_sel == 4'b0010) || (mode_sel == 4'b0100);
        // Clearing on the wrap makes the phase read 0 exactly at pulse_start.
        w_clear  = (wave_sel != r_wsel) || (w_pulsed && w_wrap);

        w_gate  = (T == '0) || (w_pw >= w_lim) || (r_per < w_pw);
        w_valid = (wave_sel != '0) && ((wave_sel & (wave_sel - 6'd1)) == '0);
        w_en    = w_valid && (!w_pulsed || w_gate);

        w_code_bit = BARKER[4'd12 - r_chip_idx];
        w_lphase   = r_phase
                   + (((wave_sel == 6'b010000) && !w_code_bit) ? 32'h8000_0000 : 32'd0)
                   + (((mode_sel == 4'b0100) && r_odd)         ? 32'h8000_0000 : 32'd0);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_phase    <= '0;
            r_ramp     <= '0;
            r_chip_cnt <= '0;
            r_chip_idx <= '0;
            r_per      <= '0;
            r_odd      <= 1'b0;
            r_wsel     <= '0;
        end else begin
            r_wsel <= wave_sel;
            r_per  <= w_per_nxt;
            if (w_wrap) r_odd <= ~r_odd;
            if (w_clear) begin
                r_phase    <= '0;
                r_ramp     <= '0;
                r_chip_cnt <= '0;
                r_chip_idx <= '0;
            end else begin
                r_phase <= r_phase + w_ftw_inst;
                r_ramp  <= r_ramp + 1'b1;
                if (r_chip_cnt == CHIP_LAST) begin
                    r_chip_cnt <= '0;
                    r_chip_idx <= (r_chip_idx == 4'd12) ? 4'd0 : r_chip_idx + 4'd1;
                end else begin
                    r_chip_cnt <= r_chip_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sin <= '0;
            r_cos <= '0;
            r_en1 <= 1'b0;
            r_sq1 <= 1'b0;
            r_dac <= '0;
        end else begin
            r_sin <= lut(w_lphase[31:22]);
            r_cos <= lut(w_lphase[31:22] + 10'd256);
            r_en1 <= w_en;
            r_sq1 <= (wave_sel == 6'b100000);
            if (!r_en1)
                r_dac <= '0;
            else if (r_sq1)
                r_dac <= {r_sin[10] ? AMP_N : AMP_P, r_cos[10] ? AMP_N : AMP_P};
            else
                r_dac <= {r_sin, r_cos};
        end
    end

    assign dac_data = r_dac;

endmodule

// File: tb/tb_dds_radar_wave.sv
`timescale 1ns/1ps
module tb_dds_radar_wave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  ws = 6'b000001;
    logic [8:0]  F = 9'd10;
    logic [10:0] T = 11'd10;
    logic [3:0]  mode = 4'b0001;
    logic [6:0]  Z = 7'd2;
    logic [21:0] dac_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: phase, clocks since last restart, period position,
    // pulses seen, previous wave_sel, and the two-deep output delay.
    bit [31:0]   m_phase;
    int          m_t, m_cnt, m_pulses;
    logic [5:0]  m_prev;
    logic [21:0] m_s1, m_exp;
    bit [12:0]   barker = 13'b1111100110101;

    dds_radar_wave dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .wave_sel (ws),
        .F        (F),
        .T        (T),
        .mode_sel (mode),
        .Z        (Z),
        .dac_data (dac_data)
    );

    always #2.5 clk = ~clk;

    function automatic int wave(input int idx, input bit cosine);
        real a, v;
        a = 2.0 * 3.141592653589793 * idx / 1024.0;
        v = cosine ? $cos(a) : $sin(a);
        return $rtoi($floor(1023.0 * v + 0.5));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_cnt = 0; m_pulses = 0;
        m_prev = '0; m_s1 = '0; m_exp = '0;
    endtask

    task automatic model_step();
        int L, pw, ncnt, c, r, si, ci;
        bit pulsed, gate, en, wrap, clr;
        longint ftw, fi;
        bit [31:0] ph;
        m_exp  = m_s1;
        L      = int'(T) * 200;
        pw     = int'(Z) * 20;
        pulsed = (mode == 4'b0010) || (mode == 4'b0100);
        gate   = (T == 0) || (pw >= L) || (m_cnt < pw);
        en     = ($countones(ws) == 1) && (!pulsed || gate);
        c      = (m_t / 20) % 13;
        ph     = m_phase;
        if (ws == 6'b010000 && barker[12 - c] == 1'b0) ph = ph + 32'h8000_0000;
        if (mode == 4'b0100 && (m_pulses % 2) == 1)    ph = ph + 32'h8000_0000;
        si = wave(int'(ph[31:22]), 1'b0);
        ci = wave(int'(ph[31:22]), 1'b1);
        if (ws == 6'b100000) begin
            si = (si >= 0) ? 1023 : -1023;
            ci = (ci >= 0) ? 1023 : -1023;
        end
        m_s1 = en ? {11'(si), 11'(ci)} : 22'd0;
        // Advance
        ncnt = (T == 0) ? 0 : ((m_cnt + 1 >= L) ? 0 : m_cnt + 1);
        wrap = (T != 0) && (ncnt == 0);
        clr  = (ws != m_prev) || (pulsed && wrap);
        ftw  = longint'(F) * 2147484;
        r    = m_t % 8192;
        case (ws)
            6'b000010: fi = (ftw * (r % 4096)) >> 12;
            6'b000100: fi = (ftw * (4095 - r % 4096)) >> 12;
            6'b001000: fi = (r < 4096) ? (ftw * r) >> 12 : (ftw * (8191 - r)) >> 12;
            default:   fi = ftw;
        endcase
        if (clr) begin
            m_phase = 0;
            m_t     = 0;
        end else begin
            m_phase = m_phase + 32'(fi);
            m_t     = m_t + 1;
        end
        if (wrap) m_pulses = m_pulses + 1;
        m_prev = ws;
        m_cnt  = ncnt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        cyc++;
        total++;
        assert (dac_data === m_exp) else begin
            bad++;
            $error("FAIL dac cyc=%0d ws=%b mode=%b got=%h exp=%h", cyc, ws, mode, dac_data, m_exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pick;
        model_reset();
        // Reset held 200 ns with CW at 1 MHz selected
        run(40);
        rst_n = 1'b1;
        run(2);
        total++;
        assert (dac_data === 22'h0003FF) else begin
            bad++;
            $error("FAIL first_sample got=%h exp=%h", dac_data, 22'h0003FF);
        end
        run(51);   // quarter period of 1 MHz: I at positive peak, Q at 0
        total++;
        assert (dac_data === 22'h1FF800) else begin
            bad++;
            $error("FAIL quarter_peak got=%h exp=%h", dac_data, 22'h1FF800);
        end
        run(400);
        // Phase-continuous frequency steps, then random carriers
        F = 9'd50;  run(200);
        F = 9'd100; run(200);
        F = 9'd400; run(200);
        for (int i = 0; i < 4; i++) begin
            F = 9'($urandom_range(1, 511));
            run(150);
        end
        // Pulsed: 40-clock 10 MHz bursts every 2000 clocks
        F = 9'd100; mode = 4'b0010; T = 11'd10; Z = 7'd2;
        run(4100);
        T = 11'd1; run(300);               // counter above new limit wraps
        T = 11'd5; Z = 7'd10; run(1100);
        T = 11'd1; Z = 7'd60; run(400);    // width beyond period: gate always on
        T = 11'd0; Z = 7'd2;  run(200);    // no period: gate on, no restarts
        // Alternate-pulse inversion
        mode = 4'b0100; T = 11'd3; Z = 7'd5; run(2000);
        // Continuous chirps, Barker, square, invalid selects
        mode = 4'b0001; F = 9'd100;
        ws = 6'b000010; run(4200);
        ws = 6'b000100; run(4200);
        ws = 6'b001000; run(8300);
        ws = 6'b010000; run(600);
        ws = 6'b100000; run(400);
        ws = 6'b000000; run(100);
        ws = 6'b000011; run(100);
        // Asynchronous reset in mid-stream
        ws = 6'b000001; F = 9'd37; run(50);
        rst_n = 1'b0;
        #1;
        total++;
        assert (dac_data === 22'd0) else begin
            bad++;
            $error("FAIL async_reset got=%h exp=%h", dac_data, 22'd0);
        end
        run(3);
        rst_n = 1'b1;
        run(100);
        // Randomized segments
        for (int s = 0; s < 16; s++) begin
            pick = $urandom_range(0, 7);
            if (pick < 6)       ws = 6'(1 << pick);
            else if (pick == 6) ws = 6'b0;
            else                ws = 6'($urandom_range(0, 63));
            F = 9'($urandom_range(0, 511));
            pick = $urandom_range(0, 3);
            mode = (pick == 0) ? 4'b0001 : (pick == 1) ? 4'b0010 :
                   (pick == 2) ? 4'b0100 : 4'($urandom_range(0, 15));
            T = 11'($urandom_range(0, 4));
            Z = 7'($urandom_range(0, 30));
            run($urandom_range(200, 600));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
